// File: rtl/rx_page_writer.sv
// rx_page_writer: serialises one multi-channel I/Q set per strobe into a
// ping-pong sample RAM (one {I,Q} word per clock), announces each filled page,
// tracks reader ownership of both pages and counts dropped sets.
module rx_page_writer #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 24,
    parameter int PAGE_AW  = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             run,
    input  logic                             in_strobe,
    input  logic [CHANNELS*2*SAMPLE_W-1:0]   in_iq,
    input  logic                             page_ack,
    input  logic                             page_ack_id,
    output logic [2*SAMPLE_W-1:0]            ram_wr_data,
    output logic [PAGE_AW:0]                 ram_wr_addr,
    output logic                             ram_wen,
    output logic                             page_done,
    output logic                             page_done_id,
    output logic [1:0]                       page_full,
    output logic                             overrun,
    output logic [15:0]                      drop_count
);

    localparam int WORD_W = 2 * SAMPLE_W;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_nx;
    logic                       page;
    logic [PAGE_AW-1:0]         word_idx;
    logic [CH_W-1:0]            ch;
    logic [CHANNELS*WORD_W-1:0] set_p0;

    logic last_ch;
    logic wrap_wr;
    logic target_page;
    logic accept;
    logic drop;

    // Saturating increment for the dropped-set counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state decode: accept/drop decisions and the RAM write strobe.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        drop     = 1'b0;
        ram_wen  = 1'b0;
        last_ch  = (ch == CH_LAST);
        wrap_wr  = (state == WRITE) && (word_idx == {PAGE_AW{1'b1}});
        // A set accepted on the last word of a page lands on the other page.
        target_page = wrap_wr ? ~page : page;
        case (state)
            IDLE: begin
                if (in_strobe) begin
                    if (!page_full[page]) begin
                        accept   = 1'b1;
                        state_nx = WRITE;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            WRITE: begin
                ram_wen = 1'b1;
                if (last_ch) begin
                    if (in_strobe && !page_full[target_page]) begin
                        accept   = 1'b1;
                        state_nx = WRITE;
                    end else begin
                        drop     = in_strobe;
                        state_nx = IDLE;
                    end
                end else begin
                    drop = in_strobe;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Receiver off: abort, rewind, and neither accept nor count strobes.
        if (!run) begin
            state_nx = IDLE;
            accept   = 1'b0;
            drop     = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Write pointer, page ownership, page announcement and drop bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            page         <= 1'b0;
            word_idx     <= '0;
            ch           <= '0;
            page_full    <= 2'b00;
            page_done    <= 1'b0;
            page_done_id <= 1'b0;
            overrun      <= 1'b0;
            drop_count   <= 16'd0;
        end else if (!run) begin
            page      <= 1'b0;
            word_idx  <= '0;
            ch        <= '0;
            page_full <= 2'b00;
            page_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            page_done <= 1'b0;
            if (page_ack) begin
                page_full[page_ack_id] <= 1'b0;
            end
            if (state == WRITE) begin
                word_idx <= word_idx + 1'b1;
                ch       <= last_ch ? '0 : ch + 1'b1;
                // Filling the page takes priority over an ack of the same page.
                if (wrap_wr) begin
                    page_full[page] <= 1'b1;
                    page_done       <= 1'b1;
                    page_done_id    <= page;
                    page            <= ~page;
                end
            end
            if (drop) begin
                overrun    <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    // Captured set; data only, so it carries no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            set_p0 <= in_iq;
        end
    end

    assign ram_wr_addr = {page, word_idx};
    assign ram_wr_data = ram_wen ? set_p0[int'(ch)*WORD_W +: WORD_W] : '0;

endmodule
